// File: rtl/exec_stage_pkg.sv
// Shared constants for the execute/writeback stage: widths, opcodes, FSM states
// and the single-cycle ALU evaluation used by exec_stage.
package exec_stage_pkg;

  localparam int WORD_SIZE = 16;
  localparam int NIB_SIZE  = 4;
  localparam int CNT_W     = $clog2(WORD_SIZE) + 1;

  typedef enum logic [NIB_SIZE-1:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9,
    OP_CMP = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MUL    = 3'd2,
    ST_SETUP  = 3'd3,
    ST_STROBE = 3'd4
  } state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] result;
    logic                 carry;
  } alu_res_t;

  // Carry is the ADD carry-out or the SUB/CMP unsigned borrow; zero otherwise.
  function automatic alu_res_t alu_eval(input logic [NIB_SIZE-1:0]  op,
                                        input logic [WORD_SIZE-1:0] a,
                                        input logic [WORD_SIZE-1:0] b);
    alu_res_t         r;
    logic [WORD_SIZE:0] sum;
    r.result = '0;
    r.carry  = 1'b0;
    sum      = '0;
    case (op)
      OP_MOV: r.result = a;
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        r.result = sum[WORD_SIZE-1:0];
        r.carry  = sum[WORD_SIZE];
      end
      OP_SUB, OP_CMP: begin
        r.result = a - b;
        r.carry  = (a < b);
      end
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_XOR: r.result = a ^ b;
      OP_SHL: r.result = a << b[3:0];
      OP_SHR: r.result = a >> b[3:0];
      default: r.result = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_stage_mul_seq.sv
// Shift-add multiplier datapath: one partial-product step per cycle, fixed
// WORD_SIZE steps. product is the accumulator value the current step produces.
module mul_seq
  import exec_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WORD_SIZE-1:0] a_in,
  input  logic [WORD_SIZE-1:0] b_in,
  output logic [WORD_SIZE-1:0] product,
  output logic                 finished
);

  logic [WORD_SIZE-1:0] a_q, a_d;
  logic [WORD_SIZE-1:0] b_q, b_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WORD_SIZE-1:0] acc_next_s;

  assign acc_next_s = acc_q + (b_q[0] ? a_q : {WORD_SIZE{1'b0}});
  assign product    = acc_next_s;
  assign finished   = (count_q == CNT_W'(WORD_SIZE - 1));

  // Next-state of the multiplier registers
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (load) begin
      a_d     = a_in;
      b_d     = b_in;
      acc_d   = '0;
      count_d = '0;
    end else if (step) begin
      acc_d   = acc_next_s;
      a_d     = a_q << 1;
      b_d     = b_q >> 1;
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Multiplier register bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage: latches operands on issue, computes the result
// (MUL via mul_seq) and presents setnum/setval a full cycle before set_strobe.
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NIB_SIZE-1:0]  op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [NIB_SIZE-1:0]  dest,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic [NIB_SIZE-1:0]  setnum,
  output logic [WORD_SIZE-1:0] setval,
  output logic                 set_strobe,
  output logic                 flag_z,
  output logic                 flag_c
);

  state_e               state_q, state_d;
  logic [NIB_SIZE-1:0]  op_q, op_d;
  logic [WORD_SIZE-1:0] a_q, a_d;
  logic [WORD_SIZE-1:0] b_q, b_d;
  logic [NIB_SIZE-1:0]  dest_q, dest_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;
  logic                 set_strobe_q, set_strobe_d;
  logic [NIB_SIZE-1:0]  setnum_q, setnum_d;
  logic [WORD_SIZE-1:0] setval_q, setval_d;
  logic                 flag_z_q, flag_z_d;
  logic                 flag_c_q, flag_c_d;

  logic                 mul_load_s, mul_step_s, mul_finished_s;
  logic [WORD_SIZE-1:0] mul_product_s;
  logic                 is_mul_s, is_write_s, is_illegal_s;
  alu_res_t             alu_s;

  assign alu_s        = alu_eval(op_q, a_q, b_q);
  assign is_mul_s     = (op_q == OP_MUL);
  assign is_write_s   = (op_q >= OP_MOV) && (op_q <= OP_SHR);
  assign is_illegal_s = (op_q > OP_CMP);

  mul_seq u_mul_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (mul_load_s),
    .step     (mul_step_s),
    .a_in     (a_q),
    .b_in     (b_q),
    .product  (mul_product_s),
    .finished (mul_finished_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; STROBE may accept a new issue so back-to-back ops lose no cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start ? ST_EXEC : ST_IDLE;
      ST_EXEC: begin
        if (is_mul_s) begin
          state_d = ST_MUL;
        end else if (is_write_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL:    state_d = mul_finished_s ? ST_SETUP : ST_MUL;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = start ? ST_EXEC : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath register next values
  always_comb begin
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    dest_d       = dest_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    set_strobe_d = 1'b0;
    setnum_d     = setnum_q;
    setval_d     = setval_q;
    flag_z_d     = flag_z_q;
    flag_c_d     = flag_c_q;
    mul_load_s   = 1'b0;
    mul_step_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_STROBE: begin
        if (start) begin
          op_d   = op;
          a_d    = a;
          b_d    = b;
          dest_d = dest;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (is_mul_s) begin
          mul_load_s = 1'b1;
        end else if (is_write_s) begin
          setnum_d = dest_q;
          setval_d = alu_s.result;
          flag_z_d = (alu_s.result == {WORD_SIZE{1'b0}});
          flag_c_d = alu_s.carry;
        end else begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          illegal_d = is_illegal_s;
          if (op_q == OP_CMP) begin
            flag_z_d = (alu_s.result == {WORD_SIZE{1'b0}});
            flag_c_d = alu_s.carry;
          end else begin
            flag_z_d = flag_z_q;
          end
        end
      end
      ST_MUL: begin
        mul_step_s = 1'b1;
        if (mul_finished_s) begin
          setnum_d = dest_q;
          setval_d = mul_product_s;
          flag_z_d = (mul_product_s == {WORD_SIZE{1'b0}});
          flag_c_d = 1'b0;
        end else begin
          setval_d = setval_q;
        end
      end
      ST_SETUP: begin
        set_strobe_d = 1'b1;
        done_d       = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // Datapath and registered-output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      dest_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      set_strobe_q <= 1'b0;
      setnum_q     <= '0;
      setval_q     <= '0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
    end else begin
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      dest_q       <= dest_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      set_strobe_q <= set_strobe_d;
      setnum_q     <= setnum_d;
      setval_q     <= setval_d;
      flag_z_q     <= flag_z_d;
      flag_c_q     <= flag_c_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign set_strobe = set_strobe_q;
  assign setnum     = setnum_q;
  assign setval     = setval_q;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: hand-computed vectors, checked with immediate
// assertions at falling-edge sample points.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [3:0]  dest = 4'd0;
  logic        busy, done, illegal, set_strobe, flag_z, flag_c;
  logic [3:0]  setnum;
  logic [15:0] setval;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int strobe_base = 0;

  exec_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .dest       (dest),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .setnum     (setnum),
    .setval     (setval),
    .set_strobe (set_strobe),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (set_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one issue; returns at the falling edge of the cycle after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] d);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dest = d;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset state
    cyc(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_strobe", set_strobe, 1'b0);
    chk("rst_flags", {illegal, flag_z, flag_c}, 3'b000);
    chk("rst_setnum", setnum, 4'd0);
    chk("rst_setval", setval, 16'h0000);
    reset_n = 1'b1;
    cyc(2);

    // ADD 0xFFFF + 2 -> dest 3
    #1 strobe_base = strobe_cnt;
    issue(4'd2, 16'hFFFF, 16'h0002, 4'd3);
    chk("add_busy_c1", busy, 1'b1);
    chk("add_strobe_c1", set_strobe, 1'b0);
    cyc(1);
    chk("add_strobe_c2", set_strobe, 1'b0);
    chk("add_setval_c2", setval, 16'h0001);
    cyc(1);
    chk("add_strobe_c3", set_strobe, 1'b1);
    chk("add_done_c3", done, 1'b1);
    chk("add_setnum", setnum, 4'd3);
    chk("add_setval", setval, 16'h0001);
    chk("add_flags_zc", {flag_z, flag_c}, 2'b01);
    cyc(1);
    chk("add_busy_after", busy, 1'b0);
    chk("add_strobe_after", set_strobe, 1'b0);
    #1 chk("add_strobe_count", strobe_cnt - strobe_base, 32'd1);

    // CMP 5,5: flags only
    strobe_base = strobe_cnt;
    issue(4'd10, 16'd5, 16'd5, 4'd9);
    chk("cmp_done_c1", done, 1'b0);
    cyc(1);
    chk("cmp_done_c2", done, 1'b1);
    chk("cmp_busy_c2", busy, 1'b0);
    chk("cmp_flags_zc", {flag_z, flag_c}, 2'b10);
    chk("cmp_setnum_held", setnum, 4'd3);
    chk("cmp_setval_held", setval, 16'h0001);
    cyc(2);
    #1 chk("cmp_no_strobe", strobe_cnt - strobe_base, 32'd0);

    // MUL 300*300 with ignored start pulses while busy
    strobe_base = strobe_cnt;
    issue(4'd9, 16'd300, 16'd300, 4'd5);
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      start = (k >= 3 && k <= 8);
      op = 4'd2; a = 16'd1; b = 16'd1; dest = 4'd14;
    end
    start = 1'b0;
    chk("mul_strobe_c18", set_strobe, 1'b0);
    chk("mul_setval_c18", setval, 16'h5F90);
    cyc(1);
    chk("mul_strobe_c19", set_strobe, 1'b1);
    chk("mul_done_c19", done, 1'b1);
    chk("mul_setnum", setnum, 4'd5);
    chk("mul_setval", setval, 16'h5F90);
    chk("mul_flags_zc", {flag_z, flag_c}, 2'b00);
    cyc(1);
    chk("mul_busy_after", busy, 1'b0);
    cyc(2);
    #1 chk("mul_strobe_count", strobe_cnt - strobe_base, 32'd1);

    // SHR 0x8000 >> 15
    issue(4'd8, 16'h8000, 16'd15, 4'd7);
    cyc(2);
    chk("shr_strobe", set_strobe, 1'b1);
    chk("shr_setval", setval, 16'h0001);
    chk("shr_setnum", setnum, 4'd7);

    // SHL 1 << 16 uses b[3:0]=0
    issue(4'd7, 16'h0001, 16'd16, 4'd8);
    cyc(2);
    chk("shl_strobe", set_strobe, 1'b1);
    chk("shl_setval", setval, 16'h0001);
    chk("shl_setnum", setnum, 4'd8);

    // ADD 0xFFFF+1 to dest 0: zero result with carry
    issue(4'd2, 16'hFFFF, 16'h0001, 4'd0);
    cyc(2);
    chk("add0_setnum", setnum, 4'd0);
    chk("add0_setval", setval, 16'h0000);
    chk("add0_flags_zc", {flag_z, flag_c}, 2'b11);
    cyc(1);

    // Illegal opcode 12
    #1 strobe_base = strobe_cnt;
    issue(4'd12, 16'h1234, 16'h0001, 4'd6);
    chk("ill_illegal_c1", illegal, 1'b0);
    cyc(1);
    chk("ill_done_illegal", {done, illegal}, 2'b11);
    chk("ill_flags_held", {flag_z, flag_c}, 2'b11);
    chk("ill_setnum_held", setnum, 4'd0);
    cyc(1);
    chk("ill_illegal_after", illegal, 1'b0);
    cyc(1);
    #1 chk("ill_no_strobe", strobe_cnt - strobe_base, 32'd0);

    // Reset mid-MUL
    strobe_base = strobe_cnt;
    issue(4'd9, 16'd3, 16'd7, 4'd9);
    cyc(7);
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_outs", {done, illegal, set_strobe, flag_z, flag_c}, 5'b00000);
    chk("mrst_setnum", setnum, 4'd0);
    chk("mrst_setval", setval, 16'h0000);
    cyc(2);
    reset_n = 1'b1;
    cyc(20);
    #1 chk("mrst_no_strobe", strobe_cnt - strobe_base, 32'd0);
    chk("mrst_idle_busy", busy, 1'b0);

    // ADD 2+2 after reset release
    issue(4'd2, 16'd2, 16'd2, 4'd1);
    cyc(2);
    chk("post_strobe", set_strobe, 1'b1);
    chk("post_setval", setval, 16'h0004);
    chk("post_setnum", setnum, 4'd1);
    chk("post_flags_zc", {flag_z, flag_c}, 2'b00);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
